bcd_display_mux: RTL

BCD_DISPLAY_MUX -- requirements
Module: bcd_display_mux

---
 rtl/bcd_display_mux.sv | 124 ++++++++++++
 1 files changed

// File: rtl/bcd_display_mux.sv
// rtl/bcd_display_mux.sv - four-digit multiplexed BCD seven-segment driver with overflow dp
// Optional leading-zero blanking: define LEADING_ZERO_BLANK_EN.
module bcd_display_mux #(
  parameter int PRESCALE = 2500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits,
  input  logic        carry_in,
  input  logic        latch,
  input  logic        clr,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        frame_done
);

  logic [15:0] snapshot;
  logic        overflow;
  logic [15:0] pre_cnt;
  logic [1:0]  idx;
  logic        tick;
  logic [3:0]  cur_digit;
  logic [6:0]  dec_seg;
  logic [6:0]  slot_seg;

  assign tick = (pre_cnt == 16'(PRESCALE - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snapshot <= 16'h0000;
    end else if (latch) begin
      snapshot <= digits;
    end
  end

  // clr has priority so a simultaneous carry cannot re-set the flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (clr) begin
      overflow <= 1'b0;
    end else if (carry_in) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= 16'd0;
      idx     <= 2'd0;
    end else if (tick) begin
      pre_cnt <= 16'd0;
      idx     <= idx + 2'd1;
    end else begin
      pre_cnt <= pre_cnt + 16'd1;
    end
  end

  always_comb begin
    cur_digit = snapshot[3:0];
    case (idx)
      2'd0: cur_digit = snapshot[3:0];
      2'd1: cur_digit = snapshot[7:4];
      2'd2: cur_digit = snapshot[11:8];
      2'd3: cur_digit = snapshot[15:12];
      default: cur_digit = snapshot[3:0];
    endcase
  end

  // Active-low {g,f,e,d,c,b,a}; non-BCD codes show "E"
  always_comb begin
    dec_seg = 7'h06;
    case (cur_digit)
      4'd0: dec_seg = 7'h40;
      4'd1: dec_seg = 7'h79;
      4'd2: dec_seg = 7'h24;
      4'd3: dec_seg = 7'h30;
      4'd4: dec_seg = 7'h19;
      4'd5: dec_seg = 7'h12;
      4'd6: dec_seg = 7'h02;
      4'd7: dec_seg = 7'h78;
      4'd8: dec_seg = 7'h00;
      4'd9: dec_seg = 7'h10;
      default: dec_seg = 7'h06;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic blank;

  // A digit is blanked only when it and every more-significant digit are zero
  always_comb begin
    blank = 1'b0;
    case (idx)
      2'd3: blank = (snapshot[15:12] == 4'd0);
      2'd2: blank = (snapshot[15:8] == 8'd0);
      2'd1: blank = (snapshot[15:4] == 12'd0);
      default: blank = 1'b0;
    endcase
  end

  assign slot_seg = blank ? 7'h7F : dec_seg;
`else
  assign slot_seg = dec_seg;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg        <= 7'h7F;
      dp         <= 1'b1;
      an         <= 4'b1111;
      frame_done <= 1'b0;
    end else begin
      frame_done <= tick && (idx == 2'd3);
      if (tick) begin
        seg <= slot_seg;
        dp  <= ~((idx == 2'd3) && overflow);
        an  <= ~(4'b0001 << idx);
      end
    end
  end

endmodule
